// File: rtl/field_scan_sel.sv
// field_scan_sel
//   Selects one W-bit field out of a packed word of N fields.
//   Direct mode (i_mode=0): registers field[i_sel] every clock. A select
//   past the last field gives zero.
//   Scan mode (i_mode=1): i_start in IDLE captures the word into a shadow
//   register. All N fields are then streamed out under valid/ready,
//   beginning at i_sel and wrapping past the last field.
//
// Ports
//   i_clk   : clock, rising edge
//   i_rst   : asynchronous reset, active low
//   i_data  : packed fields, field k = i_data[k*W +: W]
//   i_mode  : 0 = direct, 1 = scan
//   i_sel   : direct-mode field select / scan start field
//   i_start : begins a scan (sampled in IDLE only)
//   i_ready : consumer accepts o_data this cycle
//   o_data  : selected or streamed field (registered)
//   o_valid : o_data is valid
//   o_last  : o_data is the final field of the scan
//   o_busy  : scan in progress
module field_scan_sel #(
   parameter  int unsigned W    = 3,
   parameter  int unsigned N    = 4,
   localparam int unsigned SELW = $clog2(N)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [N*W-1:0]    i_data,
   input  logic              i_mode,
   input  logic [SELW-1:0]   i_sel,
   input  logic              i_start,
   input  logic              i_ready,
   output logic [W-1:0]      o_data,
   output logic              o_valid,
   output logic              o_last,
   output logic              o_busy
);

   localparam logic [SELW-1:0] LAST_IDX = SELW'(N - 1);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t            r_state, w_state_nx;
   logic [SELW-1:0]   r_idx,   w_idx_nx;
   logic [SELW-1:0]   r_cnt,   w_cnt_nx;
   logic [N*W-1:0]    r_shadow, w_shadow_nx;
   logic [W-1:0]      r_data,  w_data_nx;
   logic              r_valid, w_valid_nx;
   logic              r_last,  w_last_nx;

   logic [SELW-1:0]   w_start_idx;
   logic [SELW-1:0]   w_idx_inc;
   logic [SELW-1:0]   w_cnt_inc;

   // Selects by comparison rather than an indexed part-select, so an index
   // at or beyond N simply matches nothing and yields zero.
   function automatic logic [W-1:0] f_field(input logic [N*W-1:0] word,
                                            input logic [SELW-1:0] idx);
      f_field = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (idx == SELW'(k)) f_field = word[k*W +: W];
      end
   endfunction

   // An out-of-range start field begins the scan at field 0.
   assign w_start_idx = (32'(i_sel) < N) ? i_sel : '0;
   assign w_idx_inc   = (r_idx == LAST_IDX) ? '0 : r_idx + SELW'(1);
   assign w_cnt_inc   = r_cnt + SELW'(1);

   always_comb begin
      w_state_nx  = r_state;
      w_idx_nx    = r_idx;
      w_cnt_nx    = r_cnt;
      w_shadow_nx = r_shadow;
      w_data_nx   = r_data;
      w_valid_nx  = r_valid;
      w_last_nx   = r_last;
      case (r_state)
         IDLE: begin
            if (!i_mode) begin
               w_data_nx  = f_field(i_data, i_sel);
               w_valid_nx = 1'b1;
               w_last_nx  = 1'b0;
            end else if (!i_start) begin
               w_valid_nx = 1'b0;
               w_last_nx  = 1'b0;
            end else begin
               // First field comes straight from i_data on the capture edge,
               // since the shadow register only holds it after this edge.
               w_shadow_nx = i_data;
               w_idx_nx    = w_start_idx;
               w_cnt_nx    = '0;
               w_data_nx   = f_field(i_data, w_start_idx);
               w_valid_nx  = 1'b1;
               w_last_nx   = 1'b0;
               w_state_nx  = SCAN;
            end
         end
         SCAN: begin
            if (r_valid && i_ready) begin
               if (r_last) begin
                  w_state_nx = IDLE;
                  w_valid_nx = 1'b0;
                  w_last_nx  = 1'b0;
               end else begin
                  w_idx_nx  = w_idx_inc;
                  w_cnt_nx  = w_cnt_inc;
                  w_data_nx = f_field(r_shadow, w_idx_inc);
                  w_last_nx = (w_cnt_inc == LAST_IDX);
               end
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state  <= IDLE;
         r_idx    <= '0;
         r_cnt    <= '0;
         r_shadow <= '0;
         r_data   <= '0;
         r_valid  <= 1'b0;
         r_last   <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_idx    <= w_idx_nx;
         r_cnt    <= w_cnt_nx;
         r_shadow <= w_shadow_nx;
         r_data   <= w_data_nx;
         r_valid  <= w_valid_nx;
         r_last   <= w_last_nx;
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;
   assign o_last  = r_last;
   assign o_busy  = (r_state == SCAN);

endmodule
